mul_issue_ctrl: RTL and testbench

//  EX-stage issue/stall controller for the RV32M multiply unit. Accepts one MUL-class op from EX
//  (valid/ready), pulses startM to the iterative multiplier, stalls the pipe until done, holds the

---
 rtl/mul_issue_ctrl.sv | 103 ++++++++++
 tb/tb_mul_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: EX-stage issue/stall controller for the iterative RV32M multiplier with a one-entry result cache
module mul_issue_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        startM,
    output logic [1:0]  mul_opcode,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    input  logic [31:0] mul_result,
    input  logic        mul_done,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DdRAIN_UNUSED} state_unused_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic           cache_valid;
    logic [1:0]     cache_op;
    logic [31:0]    cache_a;
    logic [31:0]    cache_b;
    logic [31:0]    cache_data;
    logic           accept;
    logic           hit;
    logic           expired;

    assign accept   = ex_valid & ~flush & ~ex_funct3[2];
    assign hit      = cache_valid && cache_op == ex_funct3[1:0] && cache_a == ex_rs1 && cache_b == ex_rs2;
    assign expired  = timer == LAST;
    assign ex_ready = state == S_IDLE;
    assign stall    = state != S_IDLE;
    assign startM   = state == S_ISSUE && !flush;
    assign wb_valid = state == S_HOLD;

    // sequencing of one multiply: accept, start, wait for completion or timeout, hold for writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            cache_valid <= 1'b0;
            cache_op    <= '0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_data  <= '0;
            mul_opcode  <= '0;
            operand1    <= '0;
            operand2    <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    mul_opcode <= ex_funct3[1:0];
                    operand1   <= ex_rs1;
                    operand2   <= ex_rs2;
                    wb_rd      <= ex_rd;
                    if (hit) wb_data <= cache_data;
                    state      <= hit ? S_HOLD : S_ISSUE;
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT, S_DRAIN: if (mul_done) begin
                    cache_valid <= 1'b1;
                    cache_op    <= mul_opcode;
                    cache_a     <= operand1;
                    cache_b     <= operand2;
                    cache_data  <= mul_result;
                    wb_data     <= mul_result;
                    state       <= (state == S_WAIT && !flush) ? S_HOLD : S_IDLE;
                end else if (expired) begin
                    err     <= 1'b1;
                    wb_data <= '0;
                    state   <= (state == S_WAIT && !flush) ? S_HOLD : S_IDLE;
                end else begin
                    timer <= timer + 1'b1;
                    if (state == S_WAIT && flush) state <= S_DRAIN;
                end
                S_HOLD: if (flush || wb_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed and randomized checks of mul_issue_ctrl against a cycle-level reference
module tb_mul_issue_ctrl;
    logic        clk = 0, rst = 1, flush = 0, ex_valid = 0, mul_done = 0, wb_ready = 0;
    logic [2:0]  ex_funct3 = 0;
    logic [31:0] ex_rs1 = 0, ex_rs2 = 0, mul_result = 0;
    logic [4:0]  ex_rd = 0;
    logic        ex_ready, stall, startM, wb_valid, err;
    logic [1:0]  mul_opcode;
    logic [31:0] operand1, operand2, wb_data;
    logic [4:0]  wb_rd;

    mul_issue_ctrl #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .stall(stall), .startM(startM), .mul_opcode(mul_opcode), .operand1(operand1),
        .operand2(operand2), .mul_result(mul_result), .mul_done(mul_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference: phase 0 idle, 1 start, 2 multiplying, 3 result held, 4 draining
    int          ph = 0, t = 0;
    logic [1:0]  m_op = 0;
    logic [31:0] m_a = 0, m_b = 0, m_wbd = 0;
    logic [4:0]  m_rd = 0;
    logic        m_err = 0, c_v = 0;
    logic [1:0]  c_op = 0;
    logic [31:0] c_a = 0, c_b = 0, c_d = 0;
    bit          pend = 0, spur_en = 0, st, dn;
    int          rem = 0, force_d = -1;
    logic [31:0] res = 0, r;

    function automatic logic [31:0] gold(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p = (op == 2'd3) ? ua * ub : (op == 2'd2) ? sa * ub : sa * sb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // reference update plus the bench-side multiplier
    initial forever begin
        @(posedge clk);
        if (rst) begin
            ph = 0; t = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_wbd = 0;
            m_err = 0; c_v = 0; pend = 0;
        end else begin
            st = ph == 1 && !flush;
            dn = mul_done;
            r  = mul_result;
            if (ph == 0) begin
                if (ex_valid && !flush && !ex_funct3[2]) begin
                    m_op = ex_funct3[1:0]; m_a = ex_rs1; m_b = ex_rs2; m_rd = ex_rd;
                    if (c_v && c_op == m_op && c_a == m_a && c_b == m_b) begin
                        m_wbd = c_d; ph = 3;
                    end else ph = 1;
                end
            end else if (ph == 1) begin
                t = 0; ph = flush ? 0 : 2;
            end else if (ph == 2 || ph == 4) begin
                if (dn) begin
                    c_v = 1; c_op = m_op; c_a = m_a; c_b = m_b; c_d = r;
                    if (ph == 2 && !flush) begin m_wbd = r; ph = 3; end else ph = 0;
                end else if (t == 63) begin
                    m_err = 1;
                    if (ph == 2 && !flush) begin m_wbd = 0; ph = 3; end else ph = 0;
                end else begin
                    t++;
                    if (ph == 2 && flush) ph = 4;
                end
            end else if (ph == 3) begin
                if (flush || wb_ready) ph = 0;
            end
            if (st) begin
                pend = 1;
                rem = force_d > 0 ? force_d : (($urandom % 10 == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12));
                res = gold(m_op, m_a, m_b);
            end else if (pend) begin
                rem--;
                if (rem == 0) pend = 0;
            end
        end
        #1;
        if (pend && rem == 1) begin
            mul_done = 1; mul_result = res;
        end else begin
            mul_done = !pend && spur_en && ($urandom % 20 == 0);
            mul_result = $urandom;
        end
    end

    // every-cycle comparison against the reference
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("ex_ready", ex_ready, ph == 0);
            chk("stall", stall, ph != 0);
            chk("startM", startM, ph == 1 && !flush);
            chk("wb_valid", wb_valid, ph == 3);
            chk("err", err, m_err);
            if (ph == 3) begin
                chk("wb_data", wb_data, m_wbd);
                chk("wb_rd", wb_rd, m_rd);
            end
            if (ph == 1 || ph == 2) begin
                chk("mul_opcode", mul_opcode, m_op);
                chk("operand1", operand1, m_a);
                chk("operand2", operand2, m_b);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ex_valid = 1; ex_funct3 = f; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
        cyc();
        ex_valid = 0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (!wb_valid && n < 200) begin
            cyc();
            n++;
        end
    endtask

    task automatic release_wb();
        wb_ready = 1;
        cyc();
        wb_ready = 0;
    endtask

    int  lat;
    bit  saw;
    logic [31:0] pool [4] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd6};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_startM", startM, 0);
        chk("rst_err", err, 0);
        chk("rst_wb_data", wb_data, 0);

        force_d = 33;
        issue(3'b000, 32'd7, 32'd6, 5'd5);
        chk("miss_startM", startM, 1);
        chk("miss_stall", stall, 1);
        wait_wb(lat);
        chk("miss_latency", lat, 34);
        chk("miss_data", wb_data, 42);
        chk("miss_rd", wb_rd, 5);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_data", wb_data, 42);
            chk("hold_rd", wb_rd, 5);
            chk("hold_stall", stall, 1);
            chk("hold_no_start", startM, 0);
        end
        release_wb();
        chk("idle_ready", ex_ready, 1);

        issue(3'b000, 32'd7, 32'd6, 5'd9);
        chk("hit_valid", wb_valid, 1);
        chk("hit_no_start", startM, 0);
        chk("hit_data", wb_data, 42);
        chk("hit_rd", wb_rd, 9);
        release_wb();

        force_d = 10;
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd3);
        repeat (6) cyc();
        flush = 1;
        cyc();
        flush = 0;
        chk("drain_stall", stall, 1);
        chk("drain_ready", ex_ready, 0);
        saw = 0;
        lat = 0;
        while (!ex_ready && lat < 100) begin
            saw |= wb_valid;
            cyc();
            lat++;
        end
        chk("drain_no_wb", saw, 0);
        chk("drain_end_ready", ex_ready, 1);
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd3);
        chk("drain_cached", wb_data, 1);
        chk("drain_hit_valid", wb_valid, 1);
        release_wb();

        force_d = 200;
        issue(3'b011, 32'h8000_0000, 32'd4, 5'd4);
        wait_wb(lat);
        chk("timeout_latency", lat, 65);
        chk("timeout_data", wb_data, 0);
        chk("timeout_err", err, 1);
        release_wb();
        chk("err_sticky", err, 1);

        force_d = 20;
        issue(3'b000, 32'd3, 32'd3, 5'd1);
        repeat (3) cyc();
        rst = 1;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_ready", ex_ready, 1);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_err", err, 0);
        @(posedge clk);
        #1 rst = 0;
        force_d = 5;
        issue(3'b000, 32'd7, 32'd6, 5'd2);
        chk("post_rst_miss", startM, 1);
        wait_wb(lat);
        chk("post_rst_data", wb_data, 42);
        release_wb();

        force_d = -1;
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            ex_valid  = $urandom % 2;
            ex_funct3 = {($urandom % 4 == 0), 2'($urandom)};
            ex_rs1    = ($urandom % 4 == 0) ? $urandom : pool[$urandom % 4];
            ex_rs2    = pool[$urandom % 4];
            ex_rd     = 5'($urandom);
            flush     = $urandom % 20 == 0;
            wb_ready  = $urandom % 3 != 0;
            cyc();
        end
        ex_valid = 0; flush = 0; wb_ready = 0;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
